// File: rtl/exec_pkg.sv
// Purpose : shared opcode/funct codes, FSM state type and flag bit positions
//           for the exec_regbank_pipe slice.
// Latency : n/a (declarations only).  Backpressure: n/a.
package exec_pkg;

  // Major opcodes; every R-type instruction uses OP_RTYPE and selects via funct.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_ORI   = 6'b010001;
  localparam logic [5:0] OP_XORI  = 6'b010010;
  localparam logic [5:0] OP_SLAI  = 6'b011000;
  localparam logic [5:0] OP_SRLI  = 6'b011001;
  localparam logic [5:0] OP_SRAI  = 6'b011010;
  localparam logic [5:0] OP_LUI   = 6'b110000;

  // R-type funct codes.
  localparam logic [5:0] F_ADD  = 6'b001000;
  localparam logic [5:0] F_SUB  = 6'b001001;
  localparam logic [5:0] F_INC  = 6'b001010;
  localparam logic [5:0] F_DEC  = 6'b001011;
  localparam logic [5:0] F_SLT  = 6'b001100;
  localparam logic [5:0] F_SGT  = 6'b001101;
  localparam logic [5:0] F_AND  = 6'b010000;
  localparam logic [5:0] F_OR   = 6'b010001;
  localparam logic [5:0] F_XOR  = 6'b010010;
  localparam logic [5:0] F_NOR  = 6'b010011;
  localparam logic [5:0] F_NOT  = 6'b010100;
  localparam logic [5:0] F_SRL  = 6'b011001;
  localparam logic [5:0] F_SRA  = 6'b011010;
  localparam logic [5:0] F_SLA  = 6'b011011;
  localparam logic [5:0] F_HAM  = 6'b101000;
  localparam logic [5:0] F_MUL  = 6'b100000;
  localparam logic [5:0] F_MOV  = 6'b110000;
  localparam logic [5:0] F_CMOV = 6'b110001;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  // Bit positions inside the 3-bit flags output {zero, carry, overflow}.
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/exec_alu.sv
// Purpose : combinational ALU for every single-cycle op plus decode legality.
// Latency : 0 cycles (pure combinational).  Backpressure: none, no state.
// Ports   : op_i/funct_i/imm_i decoded fields, a_i=regs[rs], b_i=regs[rt];
//           res_o result, carry_o/ovf_o arithmetic flags, legal_o decode ok,
//           is_mul_o MUL request, to_rs_o dest is rs (MOV/CMOV), is_cmov_o.
module exec_alu
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      op_i,
  input  logic [5:0]      funct_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [15:0]     imm_i,
  output logic [XLEN-1:0] res_o,
  output logic            carry_o,
  output logic            ovf_o,
  output logic            legal_o,
  output logic            is_mul_o,
  output logic            to_rs_o,
  output logic            is_cmov_o
);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] simm, zimm, opb, ham;
  logic [XLEN:0]   sum;
  logic            sub, arith;
  logic [SHW-1:0]  sh_r, sh_i;

  assign simm = XLEN'($signed(imm_i));
  assign zimm = XLEN'(imm_i);
  assign sh_r = b_i[SHW-1:0];
  assign sh_i = imm_i[SHW-1:0];

  always_comb begin
    ham = '0;
    for (int i = 0; i < XLEN; i++) ham = ham + XLEN'(a_i[i]);
  end

  always_comb begin
    // One shared adder serves ADD/SUB/INC/DEC/ADDI/SUBI; the extra top bit
    // is carry-out on add and borrow on subtract.
    opb   = b_i;
    sub   = 1'b0;
    arith = 1'b0;
    if (op_i == OP_RTYPE) begin
      case (funct_i)
        F_ADD: arith = 1'b1;
        F_SUB: begin arith = 1'b1; sub = 1'b1; end
        F_INC: begin arith = 1'b1; opb = XLEN'(1); end
        F_DEC: begin arith = 1'b1; sub = 1'b1; opb = XLEN'(1); end
        default: ;
      endcase
    end else if (op_i == OP_ADDI) begin
      arith = 1'b1; opb = simm;
    end else if (op_i == OP_SUBI) begin
      arith = 1'b1; sub = 1'b1; opb = simm;
    end
    sum = sub ? ({1'b0, a_i} - {1'b0, opb}) : ({1'b0, a_i} + {1'b0, opb});

    res_o     = '0;
    legal_o   = 1'b1;
    is_mul_o  = 1'b0;
    to_rs_o   = 1'b0;
    is_cmov_o = 1'b0;
    if (op_i == OP_RTYPE) begin
      case (funct_i)
        F_ADD, F_SUB, F_INC, F_DEC: res_o = sum[XLEN-1:0];
        F_SLT:  res_o = XLEN'($signed(a_i) < $signed(b_i));
        F_SGT:  res_o = XLEN'($signed(a_i) > $signed(b_i));
        F_AND:  res_o = a_i & b_i;
        F_OR:   res_o = a_i | b_i;
        F_XOR:  res_o = a_i ^ b_i;
        F_NOR:  res_o = ~(a_i | b_i);
        F_NOT:  res_o = ~a_i;
        F_SRL:  res_o = a_i >> sh_r;
        F_SRA:  res_o = $unsigned($signed(a_i) >>> sh_r);
        F_SLA:  res_o = a_i << sh_r;
        F_HAM:  res_o = ham;
        F_MUL:  is_mul_o = 1'b1;
        F_MOV:  begin res_o = b_i; to_rs_o = 1'b1; end
        F_CMOV: begin res_o = b_i; to_rs_o = 1'b1; is_cmov_o = 1'b1; end
        default: legal_o = 1'b0;
      endcase
    end else begin
      case (op_i)
        OP_ADDI, OP_SUBI: res_o = sum[XLEN-1:0];
        OP_ANDI: res_o = a_i & zimm;
        OP_ORI:  res_o = a_i | zimm;
        OP_XORI: res_o = a_i ^ zimm;
        OP_SLAI: res_o = a_i << sh_i;
        OP_SRLI: res_o = a_i >> sh_i;
        OP_SRAI: res_o = $unsigned($signed(a_i) >>> sh_i);
        OP_LUI:  res_o = XLEN'({imm_i, 16'h0000});
        default: legal_o = 1'b0;
      endcase
    end

    carry_o = arith & sum[XLEN];
    ovf_o   = arith & (sub ? ((a_i[XLEN-1] != opb[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1]))
                           : ((a_i[XLEN-1] == opb[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1])));
  end

endmodule

// File: rtl/exec_regbank_pipe.sv
// Purpose : NREG x XLEN register bank + ALU + iterative MUL with debug port.
// Latency : single-cycle ops commit at the accept edge (outputs next cycle);
//           MUL commits XLEN/MUL_BITS edges after accept.
// Backpressure: in_ready drops for the whole MUL iteration, else always 1.
// Ports   : clk, rst (async active-low); in_valid/in_ready/instruction;
//           out_valid/out_rd/alu_result/flags/illegal; dbg_addr/dbg_rdata/
//           dbg_we/dbg_wdata.
module exec_regbank_pipe
  import exec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREG     = 16,
  parameter int MUL_BITS = 1,
  parameter int R0_ZERO  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  output logic [3:0]      out_rd,
  output logic [XLEN-1:0] alu_result,
  output logic [2:0]      flags,
  output logic            illegal,
  input  logic [3:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_rdata,
  input  logic            dbg_we,
  input  logic [XLEN-1:0] dbg_wdata
);
  localparam int MUL_CYCLES = XLEN / MUL_BITS;
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int AW = $clog2(NREG);

  state_t          state_q, state_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] mul_a_q, mul_b_q, mul_acc_q, acc_d;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      mul_rd_q, out_rd_q;
  logic [XLEN-1:0] alu_result_q;
  logic [2:0]      flags_q;
  logic            out_valid_q, illegal_q;

  logic [5:0]      op, funct;
  logic [3:0]      rs_a, rt_a, rd_a, dest;
  logic [15:0]     imm;
  logic [XLEN-1:0] rs_val, rt_val, alu_res, wr_data;
  logic            alu_c, alu_v, alu_legal, alu_mul, alu_to_rs, alu_cmov;
  logic            is_rtype, legal, accept, issue_single, issue_mul, mul_done;
  logic            wr_en, commit, reg_we, dbg_we_eff;
  logic [3:0]      wr_addr;
  logic            unused_bits;

  function automatic logic fld_ok(input logic [3:0] a);
    return 32'(a) < NREG;
  endfunction

  assign op    = instruction[31:26];
  assign rs_a  = instruction[25:22];
  assign rt_a  = instruction[21:18];
  assign rd_a  = instruction[17:14];
  assign funct = instruction[8:3];
  assign imm   = instruction[17:2];
  assign unused_bits = ^{instruction[13:9], instruction[2:0]};

  assign rs_val    = fld_ok(rs_a) ? regs_q[rs_a[AW-1:0]] : '0;
  assign rt_val    = fld_ok(rt_a) ? regs_q[rt_a[AW-1:0]] : '0;
  assign dbg_rdata = fld_ok(dbg_addr) ? regs_q[dbg_addr[AW-1:0]] : '0;

  exec_alu #(.XLEN(XLEN)) u_alu (
    .op_i      (op),
    .funct_i   (funct),
    .a_i       (rs_val),
    .b_i       (rt_val),
    .imm_i     (imm),
    .res_o     (alu_res),
    .carry_o   (alu_c),
    .ovf_o     (alu_v),
    .legal_o   (alu_legal),
    .is_mul_o  (alu_mul),
    .to_rs_o   (alu_to_rs),
    .is_cmov_o (alu_cmov)
  );

  assign is_rtype     = (op == OP_RTYPE);
  // Out-of-range register fields make the instruction illegal.
  assign legal        = alu_legal && fld_ok(rs_a) && fld_ok(rt_a) && (!is_rtype || fld_ok(rd_a));
  assign in_ready     = (state_q == IDLE);
  assign accept       = in_valid && in_ready;
  assign issue_single = accept && legal && !alu_mul;
  assign issue_mul    = accept && legal && alu_mul;
  assign mul_done     = (state_q == MUL_BUSY) && (cnt_q == CW'(MUL_CYCLES - 1));
  assign dest         = !is_rtype ? rt_a : (alu_to_rs ? rs_a : rd_a);

  // Shift-add step: retire MUL_BITS multiplier bits per cycle.
  always_comb begin
    acc_d = mul_acc_q;
    for (int j = 0; j < MUL_BITS; j++)
      if (mul_b_q[j]) acc_d = acc_d + (mul_a_q << j);
  end

  always_comb begin
    wr_en   = 1'b0;
    commit  = 1'b0;
    wr_addr = dest;
    wr_data = alu_res;
    if (mul_done) begin
      commit = 1'b1; wr_en = 1'b1; wr_addr = mul_rd_q; wr_data = acc_d;
    end else if (issue_single) begin
      // A CMOV whose condition fails still commits, it just writes nothing.
      commit = 1'b1;
      wr_en  = !alu_cmov || (rs_val != '0);
    end
  end

  assign reg_we     = wr_en && !((R0_ZERO != 0) && (wr_addr == 4'd0));
  // Instruction writeback has priority; a colliding debug write is lost.
  assign dbg_we_eff = dbg_we && !wr_en && fld_ok(dbg_addr) &&
                      !((R0_ZERO != 0) && (dbg_addr == 4'd0));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (issue_mul) state_d = MUL_BUSY;
      MUL_BUSY: if (mul_done)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_acc_q    <= '0;
      cnt_q        <= '0;
      mul_rd_q     <= '0;
      out_rd_q     <= '0;
      alu_result_q <= '0;
      flags_q      <= '0;
      out_valid_q  <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      illegal_q   <= accept && !legal;
      if (commit) begin
        out_valid_q  <= 1'b1;
        alu_result_q <= wr_data;
        out_rd_q     <= wr_addr;
        flags_q      <= {wr_data == '0, issue_single & alu_c, issue_single & alu_v};
      end
      if (reg_we)     regs_q[wr_addr[AW-1:0]]  <= wr_data;
      if (dbg_we_eff) regs_q[dbg_addr[AW-1:0]] <= dbg_wdata;
      if (issue_mul) begin
        mul_a_q   <= rs_val;
        mul_b_q   <= rt_val;
        mul_acc_q <= '0;
        cnt_q     <= '0;
        mul_rd_q  <= rd_a;
      end else if (state_q == MUL_BUSY) begin
        mul_a_q   <= mul_a_q << MUL_BITS;
        mul_b_q   <= mul_b_q >> MUL_BITS;
        mul_acc_q <= acc_d;
        cnt_q     <= cnt_q + CW'(1);
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_rd     = out_rd_q;
  assign alu_result = alu_result_q;
  assign flags      = flags_q;
  assign illegal    = illegal_q;

endmodule
